writeback_arbiter: RTL

- Shares the single completion-buffer write port among the four scalar functional units: arith, mult, div and load/store, in scalar_fu_t order.
- Selects at most one FU result per cycle using round-robin priority.
- Registers the selected result into a one-deep output stage.
- Drives the completion-buffer write (CB index, rd, wen, data) with valid/ready flow control on both sides.

---
 rtl/rv32i_types_pkg.sv | 40 ++++
 rtl/writeback_arbiter_rr_arbiter.sv | 33 +++
 rtl/writeback_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/rv32i_types_pkg.sv
// Shared RV32I core types: word, scalar FU identifiers and the writeback
// request/output records exchanged between the FUs and the completion buffer.
package rv32i_types_pkg;

    localparam int WORD_SIZE     = 32;
    localparam int NUM_CB_ENTRY  = 16;
    localparam int CB_IDX_BITS   = $clog2(NUM_CB_ENTRY);
    localparam int NUM_SCALAR_FU = 4;

    typedef logic [WORD_SIZE-1:0] word_t;

    typedef enum logic [1:0] {
        ARITH_S     = 2'd0,
        MUL_S       = 2'd1,
        DIV_S       = 2'd2,
        LOADSTORE_S = 2'd3
    } scalar_fu_t;

    typedef struct packed {
        word_t                  data;
        logic [4:0]             rd;
        logic                   wen;
        logic [CB_IDX_BITS-1:0] index;
    } wb_req_t;

    typedef struct packed {
        wb_req_t    req;
        scalar_fu_t fu;
    } wb_out_t;

    function automatic int unsigned popcount(input logic [NUM_SCALAR_FU-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < NUM_SCALAR_FU; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/writeback_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping
// modulo N, wins. The pointer itself is owned by the instantiating block.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_valid
);

    int   cand;
    logic hit;

    // Rotating priority scan; hit latches off every candidate after the first winner
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = 0;
        hit       = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand      = (int'(ptr) + k) % N;
            hit       = !gnt_valid && req[cand];
            gnt[cand] = hit;
            gnt_idx   = hit ? W'(cand) : gnt_idx;
            gnt_valid = gnt_valid | hit;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Shares the completion-buffer write port among the scalar FUs: round-robin
// grant, one-deep registered output stage, valid/ready on both sides.
module writeback_arbiter
    import rv32i_types_pkg::*;
#(
    parameter int NUM_FU   = NUM_SCALAR_FU,
    parameter int DATA_W   = WORD_SIZE,
    parameter int CB_IDX_W = CB_IDX_BITS,
    parameter int CNT_W    = 16
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic [NUM_FU-1:0]                  fu_valid,
    input  logic [NUM_FU-1:0][DATA_W-1:0]      fu_data,
    input  logic [NUM_FU-1:0][4:0]             fu_rd,
    input  logic [NUM_FU-1:0]                  fu_wen,
    input  logic [NUM_FU-1:0][CB_IDX_W-1:0]    fu_index,
    output logic [NUM_FU-1:0]                  fu_ready,
    input  logic                               cb_ready,
    output logic                               cb_valid,
    output logic [DATA_W-1:0]                  cb_data,
    output logic [4:0]                         cb_rd,
    output logic                               cb_wen,
    output logic [CB_IDX_W-1:0]                cb_index,
    output logic [1:0]                         cb_fu,
    input  logic                               flush,
    output logic [CNT_W-1:0]                   conflict_count
);

    localparam int PTR_W = $clog2(NUM_FU);

    logic              cb_valid_q, cb_valid_d;
    wb_out_t           out_q, out_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  conflict_count_q, conflict_count_d;

    logic [NUM_FU-1:0] gnt;
    logic [PTR_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic              accept;
    logic              grant_en;
    logic              handshake;
    wb_out_t           sel;

    rr_arbiter #(.N(NUM_FU), .W(PTR_W)) u_rr_arbiter (
        .req       (fu_valid),
        .ptr       (rr_ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_any)
    );

    // Grant is visible to the FUs in the same cycle; the output stage must be free or draining
    always_comb begin
        accept    = !cb_valid_q || cb_ready;
        grant_en  = accept && !flush && !RST;
        fu_ready  = grant_en ? gnt : '0;
        handshake = grant_en && gnt_any;
    end

    // Payload of the winning FU, tagged with its scalar_fu_t
    always_comb begin
        sel           = '0;
        sel.req.data  = fu_data[gnt_idx];
        sel.req.rd    = fu_rd[gnt_idx];
        sel.req.wen   = fu_wen[gnt_idx];
        sel.req.index = fu_index[gnt_idx];
        sel.fu        = scalar_fu_t'(gnt_idx);
    end

    // Output stage and pointer update; flush empties the stage but leaves the pointer alone
    always_comb begin
        cb_valid_d = cb_valid_q;
        out_d      = out_q;
        rr_ptr_d   = rr_ptr_q;
        if (flush) begin
            cb_valid_d = 1'b0;
        end else if (accept) begin
            if (handshake) begin
                cb_valid_d = 1'b1;
                out_d      = sel;
                rr_ptr_d   = (gnt_idx == PTR_W'(NUM_FU - 1)) ? '0 : gnt_idx + PTR_W'(1);
            end else begin
                cb_valid_d = 1'b0;
            end
        end else begin
            cb_valid_d = cb_valid_q;
        end
    end

    // Saturating count of cycles with contention, regardless of accept or flush
    always_comb begin
        conflict_count_d = conflict_count_q;
        if ((popcount(fu_valid) >= 32'd2) && (conflict_count_q != {CNT_W{1'b1}})) begin
            conflict_count_d = conflict_count_q + CNT_W'(1);
        end else begin
            conflict_count_d = conflict_count_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            cb_valid_q       <= 1'b0;
            out_q            <= '0;
            rr_ptr_q         <= '0;
            conflict_count_q <= '0;
        end else begin
            cb_valid_q       <= cb_valid_d;
            out_q            <= out_d;
            rr_ptr_q         <= rr_ptr_d;
            conflict_count_q <= conflict_count_d;
        end
    end

    assign cb_valid       = cb_valid_q;
    assign cb_data        = out_q.req.data;
    assign cb_rd          = out_q.req.rd;
    assign cb_wen         = out_q.req.wen;
    assign cb_index       = out_q.req.index;
    assign cb_fu          = out_q.fu;
    assign conflict_count = conflict_count_q;

endmodule
